// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder with a small register set.
// MDC/MDIO are oversampled on clk; all frame handling is edge-driven.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0DD1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  input  logic [1:0]  speed,
  output logic [15:0] ctrl_reg,
  output logic        an_restart,
  output logic        wr_pulse,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam logic [15:0] CTRL_RST = 16'h1140;

  typedef enum logic [3:0] {
    IDLE,
    START,
    OP,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDATA,
    SKIP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]  mdc_sync;
  logic [1:0]  mdio_sync;
  logic        mdc_q;
  logic        rise;
  logic        fall;
  logic        din;
  logic [4:0]  cnt;
  logic [5:0]  ones;
  logic        op_hi;
  logic        is_read;
  logic [4:0]  phyad;
  logic [4:0]  regad;
  logic [15:0] wdat;
  logic [15:0] shreg;
  logic [15:0] rd_val;
  logic [15:0] wr_word;

  assign rise    = mdc_sync[1] & ~mdc_q;
  assign fall    = ~mdc_sync[1] & mdc_q;
  assign din     = mdio_sync[1];
  assign wr_word = {wdat[14:0], din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_q     <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdio_sync <= {mdio_sync[0], mdio_i};
      mdc_q     <= mdc_sync[1];
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (regad)
      5'd0:    rd_val = ctrl_reg;
      5'd1:    rd_val = 16'h7949
                      | {10'b0, link_up, 2'b0, link_up, 2'b0};
      5'd2:    rd_val = PHY_ID1;
      5'd3:    rd_val = PHY_ID2;
      5'd17:   rd_val = {speed, 2'b10, link_up, link_up, 10'b0};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rise && !din && ones == 6'd32) state_nx = START;
      end
      START: begin
        if (rise) state_nx = din ? OP : IDLE;
      end
      OP: begin
        // 10 and 01 are the only opcodes: the two bits must differ
        if (rise && cnt[0]) state_nx = (op_hi ^ din) ? PHYAD : IDLE;
      end
      PHYAD: begin
        if (rise && cnt == 5'd4) state_nx = REGAD;
      end
      REGAD: begin
        if (rise && cnt == 5'd4)
          state_nx = (phyad == PHY_ADDR) ? TA : SKIP;
      end
      TA: begin
        if (rise) begin
          if (is_read)     state_nx = RDATA;
          else if (cnt[0]) state_nx = WDATA;
        end
      end
      WDATA: begin
        if (rise && cnt == 5'd15) state_nx = IDLE;
      end
      RDATA: begin
        if (fall && cnt == 5'd17) state_nx = IDLE;
      end
      SKIP: begin
        if (rise && cnt == 5'd17) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      ones       <= '0;
      op_hi      <= 1'b0;
      is_read    <= 1'b0;
      phyad      <= '0;
      regad      <= '0;
      wdat       <= '0;
      shreg      <= '0;
      mdio_o     <= 1'b0;
      mdio_oe    <= 1'b0;
      ctrl_reg   <= CTRL_RST;
      an_restart <= 1'b0;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_pulse   <= 1'b0;
      an_restart <= 1'b0;

      if (state_nx != state) begin
        cnt <= '0;
      end else if (state != IDLE && ((state == RDATA) ? fall : rise)) begin
        cnt <= cnt + 5'd1;
      end

      if (state == IDLE && rise) begin
        if (!din)                ones <= '0;
        else if (ones != 6'd32)  ones <= ones + 6'd1;
      end

      if (rise) begin
        unique case (state)
          OP: begin
            op_hi <= din;
            if (cnt[0]) is_read <= op_hi;
          end
          PHYAD: phyad <= {phyad[3:0], din};
          REGAD: regad <= {regad[3:0], din};
          TA: begin
            // snapshot so live inputs cannot tear the shifted word
            if (is_read) shreg <= rd_val;
          end
          WDATA: begin
            wdat <= wr_word;
            if (cnt == 5'd15) begin
              wr_pulse <= 1'b1;
              wr_addr  <= regad;
              wr_data  <= wr_word;
              if (regad == 5'd0) begin
                an_restart <= wr_word[9];
                ctrl_reg   <= wr_word[15] ? CTRL_RST
                                          : (wr_word & 16'hFDFF);
              end
            end
          end
          default: ;
        endcase
      end

      if (fall && state == RDATA) begin
        if (cnt == 5'd0) begin
          mdio_oe <= 1'b1;
          mdio_o  <= 1'b0;
        end else if (cnt == 5'd17) begin
          mdio_oe <= 1'b0;
          mdio_o  <= 1'b0;
        end else begin
          mdio_o <= shreg[15];
          shreg  <= {shreg[14:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: an MDIO master drives frames while a
// register-level model predicts read data, write strobes and drive windows.
module tb_mdio_phy_responder;

  localparam logic [4:0] PHY = 5'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        link_up = 1'b0;
  logic [1:0]  speed = 2'b00;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [15:0] ctrl_reg;
  logic        an_restart;
  logic        wr_pulse;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  logic m_en = 1'b0;
  logic m_drv = 1'b1;

  // open-drain style bus with pull-up
  assign mdio_i = mdio_oe ? mdio_o : (m_en ? m_drv : 1'b1);

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int oe_cyc = 0;

  logic [15:0] m_ctrl = 16'h1140;
  logic [15:0] pend_data = '0;
  logic [15:0] pend_ctrl = '0;
  logic [4:0]  pend_addr = '0;
  logic        pend_valid = 1'b0;
  logic        pend_rst = 1'b0;
  logic        prev_pulse = 1'b0;

  mdio_phy_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mdc        (mdc),
    .mdio_i     (mdio_i),
    .mdio_o     (mdio_o),
    .mdio_oe    (mdio_oe),
    .link_up    (link_up),
    .speed      (speed),
    .ctrl_reg   (ctrl_reg),
    .an_restart (an_restart),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] ra);
    case (ra)
      5'd0:    return m_ctrl;
      5'd1:    return 16'h7949 + (link_up ? 16'h0024 : 16'h0000);
      5'd2:    return 16'h0141;
      5'd3:    return 16'h0DD1;
      5'd17:   return 16'(speed) * 16'h4000 + 16'h2000
                      + (link_up ? 16'h0C00 : 16'h0000);
      default: return 16'h0000;
    endcase
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (mdio_oe) oe_cyc++;
      chk("bus_contention", 32'(mdio_oe & m_en), 32'd0);
      if (wr_pulse) begin
        chk("pulse_expected", 32'(pend_valid), 32'd1);
        chk("pulse_width", 32'(prev_pulse), 32'd0);
        chk("wr_addr", 32'(wr_addr), 32'(pend_addr));
        chk("wr_data", 32'(wr_data), 32'(pend_data));
        chk("ctrl_on_pulse", 32'(ctrl_reg), 32'(pend_ctrl));
        chk("an_restart", 32'(an_restart), 32'(pend_rst));
        m_ctrl = pend_ctrl;
        pend_valid = 1'b0;
        pulses++;
      end else begin
        chk("ctrl_reg", 32'(ctrl_reg), 32'(m_ctrl));
        chk("an_restart_idle", 32'(an_restart), 32'd0);
      end
      prev_pulse = wr_pulse;
    end
  end

  task automatic mcyc(input logic en, input logic b, output logic s);
    mdc = 1'b0;
    m_en = en;
    m_drv = b;
    repeat (8) @(negedge clk);
    s = mdio_i;
    mdc = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame(input int npre, input logic [1:0] op,
                       input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input bit abort,
                       output logic [15:0] rd);
    logic s;
    bit resp;
    bit isrd;
    int p0;
    logic [15:0] exp;
    isrd = (op == 2'b10);
    resp = (npre >= 32) && (op == 2'b10 || op == 2'b01) && (pa == PHY);
    exp = model_read(ra);
    rd = 16'hFFFF;
    if (resp && !isrd) begin
      pend_addr = ra;
      pend_data = wd;
      pend_rst = (ra == 5'd0) && wd[9];
      pend_ctrl = (ra != 5'd0) ? m_ctrl
                : wd[15] ? 16'h1140 : (wd & 16'hFDFF);
      pend_valid = 1'b1;
    end
    p0 = pulses;
    oe_cyc = 0;
    mcyc(1'b1, 1'b0, s);
    mcyc(1'b1, 1'b0, s);
    repeat (npre) mcyc(1'b1, 1'b1, s);
    mcyc(1'b1, 1'b0, s);
    mcyc(1'b1, 1'b1, s);
    for (int i = 1; i >= 0; i--) mcyc(1'b1, op[i], s);
    for (int i = 4; i >= 0; i--) mcyc(1'b1, pa[i], s);
    for (int i = 4; i >= 0; i--) mcyc(1'b1, ra[i], s);
    if (isrd) begin
      mcyc(1'b0, 1'b1, s);
      mcyc(1'b0, 1'b1, s);
      if (resp) chk("ta2_driven_zero", 32'(s), 32'd0);
      for (int i = 15; i >= 0; i--) begin
        mcyc(1'b0, 1'b1, s);
        rd[i] = s;
        if (abort && i == 8) begin
          mdc = 1'b0;
          repeat (2) @(negedge clk);
          chk("oe_before_reset", 32'(mdio_oe), 32'd1);
          rst_n = 1'b0;
          m_ctrl = 16'h1140;
          pend_valid = 1'b0;
          #1;
          chk("oe_in_reset", 32'(mdio_oe), 32'd0);
          chk("mdio_o_in_reset", 32'(mdio_o), 32'd0);
          chk("ctrl_in_reset", 32'(ctrl_reg), 32'h1140);
          repeat (4) @(negedge clk);
          rst_n = 1'b1;
          repeat (2) @(negedge clk);
          return;
        end
      end
    end else begin
      mcyc(1'b1, 1'b1, s);
      mcyc(1'b1, 1'b0, s);
      for (int i = 15; i >= 0; i--) mcyc(1'b1, wd[i], s);
    end
    mcyc(1'b0, 1'b1, s);
    mcyc(1'b0, 1'b1, s);
    chk("wr_pulse_count", 32'(pulses - p0), (resp && !isrd) ? 32'd1 : 32'd0);
    chk("wr_pend_done", 32'(pend_valid), 32'd0);
    chk("oe_cycles", 32'(oe_cyc), (resp && isrd) ? 32'd272 : 32'd0);
    if (isrd) chk("rd_data", 32'(rd), resp ? 32'(exp) : 32'h0000FFFF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r;
    logic [1:0]  op;
    logic [4:0]  pa;
    logic [4:0]  ra;
    int          k;
    int          np;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'(ctrl_reg), 32'h1140);
    chk("rst_oe", 32'(mdio_oe), 32'd0);
    chk("rst_mdio_o", 32'(mdio_o), 32'd0);
    chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("rst_an_restart", 32'(an_restart), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    link_up = 1'b1;
    speed = 2'b10;
    frame(32, 2'b10, PHY, 5'd17, 16'h0, 1'b0, r);
    chk("lit_reg17", 32'(r), 32'h0000AC00);

    frame(32, 2'b01, PHY, 5'd0, 16'h1340, 1'b0, r);
    chk("lit_wr_addr", 32'(wr_addr), 32'd0);
    chk("lit_wr_data", 32'(wr_data), 32'h1340);
    chk("lit_ctrl_1340", 32'(ctrl_reg), 32'h1140);
    frame(32, 2'b10, PHY, 5'd0, 16'h0, 1'b0, r);
    chk("lit_reg0", 32'(r), 32'h1140);

    frame(32, 2'b10, 5'd2, 5'd0, 16'h0, 1'b0, r);
    frame(32, 2'b10, PHY, 5'd2, 16'h0, 1'b0, r);
    chk("lit_after_skip", 32'(r), 32'h0141);

    frame(31, 2'b10, PHY, 5'd2, 16'h0, 1'b0, r);
    chk("lit_31_ones", 32'(r), 32'h0000FFFF);
    frame(32, 2'b10, PHY, 5'd2, 16'h0, 1'b0, r);
    chk("lit_reg2", 32'(r), 32'h0141);

    frame(32, 2'b01, PHY, 5'd0, 16'h0100, 1'b0, r);
    chk("lit_ctrl_0100", 32'(ctrl_reg), 32'h0100);
    frame(32, 2'b01, PHY, 5'd0, 16'h8000, 1'b0, r);
    chk("lit_ctrl_reset", 32'(ctrl_reg), 32'h1140);
    link_up = 1'b0;
    frame(32, 2'b10, PHY, 5'd1, 16'h0, 1'b0, r);
    chk("lit_reg1", 32'(r), 32'h7949);

    frame(32, 2'b10, PHY, 5'd3, 16'h0, 1'b1, r);
    frame(32, 2'b10, PHY, 5'd3, 16'h0, 1'b0, r);
    chk("lit_reg3", 32'(r), 32'h0DD1);

    for (int n = 0; n < 30; n++) begin
      link_up = 1'($urandom_range(0, 1));
      speed = 2'($urandom_range(0, 3));
      np = ($urandom_range(0, 7) == 0) ? 31 : 32 + $urandom_range(0, 2);
      k = $urandom_range(0, 9);
      op = (k == 0) ? 2'b00 : (k == 1) ? 2'b11 : (k < 6) ? 2'b10 : 2'b01;
      pa = ($urandom_range(0, 4) == 0) ? 5'(1 + $urandom_range(1, 31)) : PHY;
      k = $urandom_range(0, 5);
      ra = (k == 0) ? 5'd0 : (k == 1) ? 5'd1 : (k == 2) ? 5'd2 :
           (k == 3) ? 5'd3 : (k == 4) ? 5'd17 : 5'($urandom_range(4, 31));
      frame(np, op, pa, ra, 16'($urandom), 1'b0, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
